para_ring_tx: RTL and testbench

PARA_RING_TX -- requirements
Module: para_ring_tx

---
 rtl/para_pkg.sv | 12 +
 rtl/para_tx_fifo.sv | 40 ++++
 rtl/para_ring_tx.sv | 101 ++++++++++
 tb/tb_para_ring_tx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// para_pkg: shared framer state encoding, default frame marker and frame lengths.
// Optional macro PARA_TX_CSUM_EN adds the SUM state (5-byte frames).
package para_pkg;
`ifdef PARA_TX_CSUM_EN
    typedef enum logic [2:0] {IDLE, HEAD, SEQ, RHI, RLO, SUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEAD, SEQ, RHI, RLO} state_t;
`endif
    localparam logic [7:0] HEAD_BYTE_DEF = 8'hA5;
    localparam int FRAME_LEN_NOSUM = 4;
    localparam int FRAME_LEN_SUM = 5;
endpackage

// File: rtl/para_tx_fifo.sv
// para_tx_fifo: synchronous show-ahead queue with full/empty/level; DEPTH must be a power of two.
module para_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   lvl
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            lvl <= lvl + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = lvl == (AW+1)'(DEPTH);
    assign empty = lvl == '0;
endmodule

// File: rtl/para_ring_tx.sv
// para_ring_tx: queues ring values and frames them as HEAD,seq,ring_hi,ring_lo[,sum] bytes.
// Define PARA_TX_CSUM_EN to append the XOR checksum byte.
module para_ring_tx
    import para_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter logic [7:0] HEAD_BYTE = HEAD_BYTE_DEF
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic [15:0]                   ph_ring,
    input  logic                          ph_vld,
    input  logic                          cfg_tx_en,
    output logic [7:0]                    tx_data,
    output logic                          tx_vld,
    input  logic                          tx_rdy,
    output logic [15:0]                   stu_tx_cnt,
    output logic [15:0]                   stu_ovf_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   stu_fifo_lvl
);
`ifdef PARA_TX_CSUM_EN
    localparam state_t LAST_ST = SUM;
`else
    localparam state_t LAST_ST = RLO;
`endif

    state_t      state, state_n;
    logic [15:0] ring_q, fifo_dout, cnt_n;
    logic [7:0]  seq_q, byte_n;
    logic        full, empty, push, pop, req, drop, acc, done;
    state_t      next_frame;

    para_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk   (clk_sys),
        .rst   (rst),
        .push  (push),
        .din   (ph_ring),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .lvl   (stu_fifo_lvl)
    );

    assign req  = ph_vld && cfg_tx_en;
    assign push = req && (!full || pop);
    assign drop = req && full && !pop;

    always_comb begin
        acc        = tx_vld && tx_rdy;
        done       = acc && state == LAST_ST;
        next_frame = empty ? IDLE : HEAD;
        state_n    = state;
        case (state)
            IDLE:    state_n = next_frame;
            HEAD:    state_n = acc ? SEQ : HEAD;
            SEQ:     state_n = acc ? RHI : SEQ;
            RHI:     state_n = acc ? RLO : RHI;
`ifdef PARA_TX_CSUM_EN
            RLO:     state_n = acc ? SUM : RLO;
            SUM:     state_n = acc ? next_frame : SUM;
`else
            RLO:     state_n = acc ? next_frame : RLO;
`endif
            default: state_n = IDLE;
        endcase
        // Popping on the last accepted byte chains frames without an idle gap.
        pop    = !empty && (state == IDLE || done);
        cnt_n  = stu_tx_cnt + 16'(done);
        byte_n = state_n == HEAD ? HEAD_BYTE :
                 state_n == SEQ  ? seq_q :
                 state_n == RHI  ? ring_q[15:8] :
                 state_n == RLO  ? ring_q[7:0] :
`ifdef PARA_TX_CSUM_EN
                 state_n == SUM  ? seq_q ^ ring_q[15:8] ^ ring_q[7:0] :
`endif
                 8'h00;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ring_q      <= '0;
            seq_q       <= '0;
            tx_data     <= '0;
            tx_vld      <= 1'b0;
            stu_tx_cnt  <= '0;
            stu_ovf_cnt <= '0;
        end else begin
            state      <= state_n;
            tx_data    <= byte_n;
            tx_vld     <= state_n != IDLE;
            stu_tx_cnt <= cnt_n;
            if (pop) begin
                ring_q <= fifo_dout;
                seq_q  <= cnt_n[7:0];
            end
            if (drop && stu_ovf_cnt != 16'hFFFF) stu_ovf_cnt <= stu_ovf_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_para_ring_tx.sv
// tb_para_ring_tx: directed checks of framing, backpressure, overflow, gating, wrap and reset.
module tb_para_ring_tx;
`ifdef PARA_TX_CSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif
    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ph_ring = '0;
    logic        ph_vld = 1'b0;
    logic        cfg_tx_en = 1'b1;
    logic        tx_rdy = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic [15:0] stu_tx_cnt, stu_ovf_cnt;
    logic [3:0]  stu_fifo_lvl;
    int          n_chk = 0;
    int          n_err = 0;

    para_ring_tx #(.FIFO_DEPTH(8), .HEAD_BYTE(8'hA5)) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .ph_ring      (ph_ring),
        .ph_vld       (ph_vld),
        .cfg_tx_en    (cfg_tx_en),
        .tx_data      (tx_data),
        .tx_vld       (tx_vld),
        .tx_rdy       (tx_rdy),
        .stu_tx_cnt   (stu_tx_cnt),
        .stu_ovf_cnt  (stu_ovf_cnt),
        .stu_fifo_lvl (stu_fifo_lvl)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] ring);
        ph_ring = ring;
        ph_vld  = 1'b1;
        @(negedge clk_sys);
        ph_vld  = 1'b0;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(tx_vld), 32'd1);
        chk(tag, 32'(tx_data), 32'(exp));
        @(negedge clk_sys);
    endtask

    task automatic chk_frame(input logic [15:0] ring, input logic [7:0] seq);
        chk_byte("head", 8'hA5);
        chk_byte("seq", seq);
        chk_byte("rhi", ring[15:8]);
        chk_byte("rlo", ring[7:0]);
        if (FL == 5) chk_byte("sum", seq ^ ring[15:8] ^ ring[7:0]);
    endtask

    initial begin
        repeat (2) @(negedge clk_sys);
        chk("rst_vld", 32'(tx_vld), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_txcnt", 32'(stu_tx_cnt), 0);
        chk("rst_ovf", 32'(stu_ovf_cnt), 0);
        chk("rst_lvl", 32'(stu_fifo_lvl), 0);
        rst = 1'b0;
        @(negedge clk_sys);

        // single frame, N+2 latency
        push(16'h1234);
        chk("lat_lvl", 32'(stu_fifo_lvl), 1);
        chk("lat_vld_n1", 32'(tx_vld), 0);
        @(negedge clk_sys);
        chk_frame(16'h1234, 8'h00);
        chk("single_idle", 32'(tx_vld), 0);
        chk("single_cnt", 32'(stu_tx_cnt), 1);

        // backpressure during RHI
        push(16'h1234);
        @(negedge clk_sys);
        chk_byte("bp_head", 8'hA5);
        chk_byte("bp_seq", 8'h01);
        tx_rdy = 1'b0;
        repeat (10) begin
            chk("bp_hold_vld", 32'(tx_vld), 1);
            chk("bp_hold_data", 32'(tx_data), 32'h12);
            @(negedge clk_sys);
        end
        tx_rdy = 1'b1;
        chk_byte("bp_rhi", 8'h12);
        chk_byte("bp_rlo", 8'h34);
        if (FL == 5) chk_byte("bp_sum", 8'h27);
        chk("bp_idle", 32'(tx_vld), 0);
        chk("bp_cnt", 32'(stu_tx_cnt), 2);

        // enable gating
        cfg_tx_en = 1'b0;
        repeat (3) push(16'hDEAD);
        repeat (5) @(negedge clk_sys);
        chk("gate_vld", 32'(tx_vld), 0);
        chk("gate_lvl", 32'(stu_fifo_lvl), 0);
        chk("gate_ovf", 32'(stu_ovf_cnt), 0);
        cfg_tx_en = 1'b1;
        push(16'hBEEF);
        @(negedge clk_sys);
        cfg_tx_en = 1'b0;
        chk_frame(16'hBEEF, 8'h02);
        cfg_tx_en = 1'b1;
        chk("gate_cnt", 32'(stu_tx_cnt), 3);

        // asynchronous reset during SEQ
        push(16'h5555);
        @(negedge clk_sys);
        chk_byte("rm_head", 8'hA5);
        #1 rst = 1'b1;
        #1;
        chk("rm_vld", 32'(tx_vld), 0);
        chk("rm_data", 32'(tx_data), 0);
        chk("rm_cnt", 32'(stu_tx_cnt), 0);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk_sys);
            chk("rm_quiet", 32'(tx_vld), 0);
        end
        chk("rm_lvl", 32'(stu_fifo_lvl), 0);

        // overflow: one value held by framer, 8 queued, 2 dropped
        tx_rdy = 1'b0;
        for (int i = 0; i < 11; i++) push(16'h0100 + 16'(i));
        chk("ovf_lvl", 32'(stu_fifo_lvl), 8);
        chk("ovf_cnt", 32'(stu_ovf_cnt), 2);
        tx_rdy = 1'b1;
        for (int i = 0; i < 9; i++) chk_frame(16'h0100 + 16'(i), 8'(i));
        chk("ovf_idle", 32'(tx_vld), 0);
        chk("ovf_txcnt", 32'(stu_tx_cnt), 9);
        chk("ovf_lvl_end", 32'(stu_fifo_lvl), 0);

        // wrap of the frame counter
        force dut.stu_tx_cnt = 16'hFFFF;
        #1 release dut.stu_tx_cnt;
        chk("wrap_pre", 32'(stu_tx_cnt), 32'hFFFF);
        push(16'hABCD);
        @(negedge clk_sys);
        chk_frame(16'hABCD, 8'hFF);
        chk("wrap_cnt", 32'(stu_tx_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
